// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port: datapath width and the
// arbiter state encoding. The datapath and hazard unit import the same
// definitions so that all three agree on the encoding.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Machine word width.
  localparam int XLEN = 32;

  // Width of the starvation counter; wide enough for limits up to 15.
  localparam int STARVE_W = 4;

  // Arbiter state: waiting for a request, or owning the memory port on
  // behalf of the fetch stage or the memory stage.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency, single-ported memory between the fetch stage
// (IF) and the memory stage (MEM). One access is in flight at a time; the
// memory port signals are registered and held until mem_ready. Completion is
// reported with a one-cycle ready pulse and registered read data.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr          fetch request (held until if_ready)
//   if_ready/if_rdata       fetch completion pulse and instruction word
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ready)
//   dm_ready/dm_rdata       data completion pulse and load data
//   mem_valid/mem_we/mem_addr/mem_wdata  request to memory, held until ready
//   mem_rdata/mem_ready     memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4  // 1..15 consecutive data grants before fetch is forced
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_ready,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;

  logic if_pend;
  logic dm_pend;
  logic starved;
  logic grant_if;
  logic grant_dm;

  // A requester whose ready pulse is out this cycle still holds its req high;
  // masking it here stops the same access from being granted twice.
  assign if_pend  = if_req & ~if_ready;
  assign dm_pend  = dm_req & ~dm_ready;
  assign starved  = (starve_cnt == LIMIT);

  // Data normally wins (it belongs to the older instruction) unless fetch
  // has been passed over STARVE_LIMIT times in a row.
  assign grant_if = (state == IDLE) & if_pend & (~dm_pend | starved);
  assign grant_dm = (state == IDLE) & dm_pend & ~grant_if;

  // NOTE: state and outputs are updated with non-blocking assignments so every
  // reader in this clock edge sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      // NOTE: default-low ahead of the case makes each ready a single-cycle
      // pulse without having to clear it in every branch.
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= FETCH;
            mem_valid  <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else if (grant_dm) begin
            state     <= DATA;
            mem_valid <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Count data grants that overtake a waiting fetch; the raw
            // if_req is used, so a fetch that is just completing still counts.
            if (!if_req) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end
        end

        FETCH: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            if_rdata  <= mem_rdata;
            if_ready  <= 1'b1;
          end
        end

        DATA: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            // Stores leave the previous load data visible.
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (STARVE_LIMIT = 2). A small memory model
// answers with a programmable number of wait states and returns
// addr ^ 32'hFFFF_0000 as read data. Single-requester accesses come from a
// vector table; arbitration, starvation and reset-abort are hand sequences.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic            clk;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ready;
  logic [XLEN-1:0] if_rdata;
  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_ready;
  logic [XLEN-1:0] dm_rdata;
  logic            mem_valid;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ready (dm_ready),
    .dm_rdata (dm_rdata),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int   mem_waits = 0;
  int   wait_cnt  = 0;
  logic stray     = 1'b0;  // drive mem_ready while mem_valid is low

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (wait_cnt == mem_waits) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr ^ 32'hFFFF_0000;
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = stray;
        mem_rdata = stray ? 32'h1234_5678 : 32'h0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- grant / pulse monitor ----------------
  bit   glog[$];          // 1 = data grant, 0 = fetch grant
  logic prev_valid = 1'b0;
  int   if_pulses  = 0;
  int   dm_pulses  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid && !prev_valid) glog.push_back(mem_addr[31:28] == 4'h1);
      prev_valid = mem_valid;
      if (if_ready) if_pulses++;
      if (dm_ready) dm_pulses++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          exp_lat;   // request cycle N to ready pulse
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          lat;
    int          if_lat;
    int          dm_lat;
    int          snap_if;
    int          snap_dm;
    logic [5:0]  order;
    bit          seen;

    vecs[0] = '{1'b1, 1'b0, 32'h0040_0000, 32'h0,         0, 2, 32'hFFBF_0000, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h1001_0004, 32'h0,         2, 4, 32'hFFBF_0000, 32'hEFFE_0004};
    vecs[2] = '{1'b0, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 0, 2, 32'hFFBF_0000, 32'hEFFE_0004};
    vecs[3] = '{1'b1, 1'b0, 32'h0040_0004, 32'h0,         1, 3, 32'hFFBF_0004, 32'hEFFE_0004};
    vecs[4] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         0, 2, 32'hFFBF_0004, 32'hEFFE_0008};

    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    reset  = 1'b1;

    // ---- reset state ----
    #2 reset = 1'b0;
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_addr",  mem_addr,       32'h0);
    check("rst_readies",   32'({if_ready, dm_ready, mem_we}), 32'h0);
    check("rst_rdata",     if_rdata | dm_rdata | mem_wdata,   32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ---- table-driven single accesses ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_waits = vecs[i].waits;
      if (vecs[i].is_fetch) begin
        if_req  = 1'b1;
        if_addr = vecs[i].addr;
      end else begin
        dm_req   = 1'b1;
        dm_we    = vecs[i].we;
        dm_addr  = vecs[i].addr;
        dm_wdata = vecs[i].wdata;
      end
      lat  = 0;
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(negedge clk);
        if (c == 1) begin
          check($sformatf("v%0d_valid_n1", i), 32'(mem_valid), 32'h1);
          check($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].we & ~vecs[i].is_fetch));
          if (vecs[i].we) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
        end
        if (mem_valid) check($sformatf("v%0d_addr_c%0d", i, c), mem_addr, vecs[i].addr);
        if (vecs[i].is_fetch ? if_ready : dm_ready) begin
          seen   = 1'b1;
          lat    = c;
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_if);
      check($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_dm);
      @(negedge clk);
      check($sformatf("v%0d_pulse_width", i), 32'({if_ready, dm_ready}), 32'h0);
      check($sformatf("v%0d_no_regrant", i), 32'(mem_valid), 32'h0);
    end

    // ---- mem_ready with mem_valid low is ignored ----
    snap_if = if_pulses;
    snap_dm = dm_pulses;
    @(negedge clk);
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_no_pulse", 32'(if_pulses + dm_pulses), 32'(snap_if + snap_dm));
    check("stray_rdata", if_rdata ^ dm_rdata, 32'hFFBF_0004 ^ 32'hEFFE_0008);

    // ---- simultaneous requests: data first, fetch in the dm_ready cycle ----
    mem_waits = 0;
    @(negedge clk);
    glog.delete();
    if_req  = 1'b1; if_addr = 32'h0040_0010;
    dm_req  = 1'b1; dm_we   = 1'b0; dm_addr = 32'h1001_000C;
    if_lat  = 0;
    dm_lat  = 0;
    for (int c = 1; c <= 30 && (if_lat == 0 || dm_lat == 0); c++) begin
      @(negedge clk);
      if (dm_ready && dm_lat == 0) begin dm_lat = c; dm_req = 1'b0; end
      if (if_ready && if_lat == 0) begin if_lat = c; if_req = 1'b0; end
    end
    repeat (3) @(negedge clk);
    check("both_dm_latency", 32'(dm_lat), 32'd2);
    check("both_if_latency", 32'(if_lat), 32'd4);
    check("both_grant_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) check("both_grant_order", 32'({glog[0], glog[1]}), 32'b10);
    check("both_if_rdata", if_rdata, 32'hFFBF_0010);
    check("both_dm_rdata", dm_rdata, 32'hEFFE_000C);

    // ---- starvation: STARVE_LIMIT = 2 ----
    // The fetch requester is stalled in the cycle dm_ready pulses, the way the
    // hazard unit holds F while M completes; otherwise it keeps requesting.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    glog.delete();
    if_addr = 32'h0040_0100;
    dm_we   = 1'b0;
    dm_addr = 32'h1001_0100;
    for (int c = 0; c < 80 && glog.size() < 6; c++) begin
      if_req = ~dm_ready;
      dm_req = 1'b1;
      @(negedge clk);
      if (if_ready) if_addr = if_addr + 32'd4;
      if (dm_ready) dm_addr = dm_addr + 32'd4;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (6) @(negedge clk);
    check("starve_grant_count", 32'(glog.size()), 32'd6);
    order = '0;
    for (int i = 0; i < 6 && i < glog.size(); i++) order[5-i] = glog[i];
    check("starve_order_DDFDDF", 32'(order), 32'(6'b110110));

    // ---- reset in the middle of a data access ----
    mem_waits = 5;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0200;
    snap_dm = dm_pulses;
    repeat (2) @(negedge clk);
    check("abort_pre_valid", 32'(mem_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_valid", 32'(mem_valid), 32'h0);
    check("abort_mem_bus", mem_addr | mem_wdata | 32'(mem_we), 32'h0);
    check("abort_rdata", if_rdata | dm_rdata, 32'h0);
    check("abort_readies", 32'({if_ready, dm_ready}), 32'h0);
    dm_req    = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0040_0020;
    mem_waits = 0;
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (if_ready) begin lat = c; if_req = 1'b0; end
    end
    repeat (2) @(negedge clk);
    check("post_rst_if_latency", 32'(lat), 32'd2);
    check("post_rst_if_rdata", if_rdata, 32'hFFBF_0020);
    check("abort_no_dm_ready", 32'(dm_pulses), 32'(snap_dm));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
